// File: rtl/sum_accumulator.sv
// Accumulates N_SAMPLES 9-bit adder results {C8,Sum} into a saturating 16-bit frame total; 1-cycle update latency.
// in_ready drops while a finished frame is held; the frame stays stable until out_ready takes it.
module sum_accumulator #(
    parameter int N_SAMPLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  Sum,
    input  logic        C8,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Total,
    output logic [7:0]  Count,
    output logic        Overflow
);

    localparam logic ST_ACCUM = 1'b0;
    localparam logic ST_HOLD  = 1'b1;

    // Count value that the frame-completing accept starts from.
    localparam logic [7:0] LAST_COUNT = 8'(N_SAMPLES - 1);

    logic        state;
    logic [15:0] total_q;
    logic [7:0]  count_q;
    logic        overflow_q;

    logic        accept;
    logic        consume;
    logic [16:0] sum_wide;
    logic        sat;
    logic [15:0] total_next;

    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_HOLD);
    assign accept    = in_valid && in_ready;
    assign consume   = out_ready && out_valid;

    // Operand is zero-extended to 17 bits so bit 16 flags any excursion past 65535.
    assign sum_wide   = {1'b0, total_q} + {8'b0, C8, Sum};
    assign sat        = sum_wide[16];
    assign total_next = sat ? 16'hFFFF : sum_wide[15:0];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state      <= ST_ACCUM;
            total_q    <= 16'd0;
            count_q    <= 8'd0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        total_q    <= total_next;
                        count_q    <= count_q + 8'd1;
                        overflow_q <= overflow_q | sat;
                        if (count_q == LAST_COUNT) begin
                            state <= ST_HOLD;
                        end
                    end
                end
                default: begin
                    if (consume) begin
                        state      <= ST_ACCUM;
                        total_q    <= 16'd0;
                        count_q    <= 8'd0;
                        overflow_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign Total    = total_q;
    assign Count    = count_q;
    assign Overflow = overflow_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Drives three accumulators (N_SAMPLES = 4, 255, 1) from shared stimulus and checks each against a frame-level model.
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] sum_in = 8'd0;
    logic       c8_in = 1'b0;
    logic       out_ready = 1'b0;

    logic [15:0] tot [3];
    logic [7:0]  cnt [3];
    logic        ovf [3];
    logic        ir  [3];
    logic        ov  [3];

    int m_total [3];
    int m_count [3];
    bit m_ovf   [3];
    bit m_hold  [3];
    int nsamp   [3] = '{4, 255, 1};

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sum_accumulator #(.N_SAMPLES(4)) dut4 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(ir[0]),
        .Sum(sum_in), .C8(c8_in), .out_valid(ov[0]), .out_ready(out_ready),
        .Total(tot[0]), .Count(cnt[0]), .Overflow(ovf[0])
    );
    sum_accumulator #(.N_SAMPLES(255)) dut255 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(ir[1]),
        .Sum(sum_in), .C8(c8_in), .out_valid(ov[1]), .out_ready(out_ready),
        .Total(tot[1]), .Count(cnt[1]), .Overflow(ovf[1])
    );
    sum_accumulator #(.N_SAMPLES(1)) dut1 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(ir[2]),
        .Sum(sum_in), .C8(c8_in), .out_valid(ov[2]), .out_ready(out_ready),
        .Total(tot[2]), .Count(cnt[2]), .Overflow(ovf[2])
    );

    task automatic drive(input bit rst, input bit clr, input bit vld, input int val, input bit ordy);
        reset     = rst;
        clear     = clr;
        in_valid  = vld;
        {c8_in, sum_in} = 9'(val);
        out_ready = ordy;
    endtask

    // Advance one clock and apply the frame rules to every model on that edge.
    task automatic step();
        int s;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (reset || clear) begin
                m_total[i] = 0; m_count[i] = 0; m_ovf[i] = 0; m_hold[i] = 0;
            end else if (!m_hold[i] && in_valid) begin
                s = m_total[i] + int'({c8_in, sum_in});
                if (s > 65535) begin
                    m_total[i] = 65535;
                    m_ovf[i] = 1;
                end else begin
                    m_total[i] = s;
                end
                m_count[i]++;
                if (m_count[i] == nsamp[i]) m_hold[i] = 1;
            end else if (m_hold[i] && out_ready) begin
                m_total[i] = 0; m_count[i] = 0; m_ovf[i] = 0; m_hold[i] = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 1, 511, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({tot[i], cnt[i], ovf[i], ir[i], ov[i]} !== {16'd0, 8'd0, 1'b0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL reset dut%0d: got total=%0d count=%0d ovf=%b in_ready=%b out_valid=%b, want 0/0/0/1/0",
                         i, tot[i], cnt[i], ovf[i], ir[i], ov[i]);
            end
        end
    endtask

    task automatic test_frame_hold();
        int vals [4] = '{199, 55, 200, 312};
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 1, vals[k], 0);
            step();
        end
        n_checks++;
        if ({ov[0], tot[0], cnt[0], ovf[0]} !== {1'b1, 16'd766, 8'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL frame766: got out_valid=%b total=%0d count=%0d ovf=%b, want 1/766/4/0",
                     ov[0], tot[0], cnt[0], ovf[0]);
        end
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 1, $urandom_range(511), 0);
            step();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if ({tot[i], cnt[i], ovf[i], ir[i], ov[i]} !==
                    {16'(m_total[i]), 8'(m_count[i]), m_ovf[i], !m_hold[i], m_hold[i]}) begin
                    n_fail++;
                    $display("FAIL hold dut%0d: got %0d/%0d/%b/%b/%b want %0d/%0d/%b/%b/%b", i,
                             tot[i], cnt[i], ovf[i], ir[i], ov[i],
                             m_total[i], m_count[i], m_ovf[i], !m_hold[i], m_hold[i]);
                end
            end
        end
        n_checks++;
        if ({tot[0], ir[0]} !== {16'd766, 1'b0}) begin
            n_fail++;
            $display("FAIL hold766: got total=%0d in_ready=%b, want 766/0", tot[0], ir[0]);
        end
        drive(0, 0, 0, 0, 1);
        step();
        n_checks++;
        if ({tot[0], cnt[0], ir[0], ov[0]} !== {16'd0, 8'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL consume: got total=%0d count=%0d in_ready=%b out_valid=%b, want 0/0/1/0",
                     tot[0], cnt[0], ir[0], ov[0]);
        end
    endtask

    task automatic test_clear();
        drive(1, 0, 0, 0, 0); step();
        drive(0, 0, 1, 199, 0); step();
        drive(0, 0, 1, 55, 0); step();
        drive(0, 1, 1, 77, 0); step();
        n_checks++;
        if ({tot[0], cnt[0], ir[0]} !== {16'd0, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL clear: got total=%0d count=%0d in_ready=%b, want 0/0/1", tot[0], cnt[0], ir[0]);
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 1, 10, 0);
            step();
        end
        n_checks++;
        if ({ov[0], tot[0], cnt[0]} !== {1'b1, 16'd40, 8'd4}) begin
            n_fail++;
            $display("FAIL after_clear: got out_valid=%b total=%0d count=%0d, want 1/40/4", ov[0], tot[0], cnt[0]);
        end
    endtask

    task automatic test_reset_in_hold();
        drive(1, 1, 1, 0, 1);
        step();
        n_checks++;
        if ({ov[0], tot[0], cnt[0], ir[0]} !== {1'b0, 16'd0, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_hold: got out_valid=%b total=%0d count=%0d in_ready=%b, want 0/0/0/1",
                     ov[0], tot[0], cnt[0], ir[0]);
        end
    endtask

    task automatic test_single();
        drive(1, 0, 0, 0, 0); step();
        drive(0, 0, 1, 300, 0); step();
        n_checks++;
        if ({ov[2], ir[2], tot[2], cnt[2]} !== {1'b1, 1'b0, 16'd300, 8'd1}) begin
            n_fail++;
            $display("FAIL single: got out_valid=%b in_ready=%b total=%0d count=%0d, want 1/0/300/1",
                     ov[2], ir[2], tot[2], cnt[2]);
        end
    endtask

    task automatic test_saturate();
        drive(1, 0, 0, 0, 0); step();
        for (int k = 1; k <= 255; k++) begin
            drive(0, 0, 1, 511, 0);
            step();
            n_checks++;
            if ({tot[1], cnt[1], ovf[1]} !== {16'(m_total[1]), 8'(m_count[1]), m_ovf[1]}) begin
                n_fail++;
                $display("FAIL saturate accept %0d: got total=%0d count=%0d ovf=%b, want %0d/%0d/%b",
                         k, tot[1], cnt[1], ovf[1], m_total[1], m_count[1], m_ovf[1]);
            end
            if (k == 128 || k == 129) begin
                n_checks++;
                if (ovf[1] !== (k == 129)) begin
                    n_fail++;
                    $display("FAIL ovf_edge accept %0d: got ovf=%b want %b", k, ovf[1], k == 129);
                end
            end
        end
        n_checks++;
        if ({ov[1], tot[1], cnt[1], ovf[1]} !== {1'b1, 16'hFFFF, 8'd255, 1'b1}) begin
            n_fail++;
            $display("FAIL sat_final: got out_valid=%b total=%0d count=%0d ovf=%b, want 1/65535/255/1",
                     ov[1], tot[1], cnt[1], ovf[1]);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(99) == 0, $urandom_range(49) == 0, $urandom_range(1) == 1,
                  $urandom_range(511), $urandom_range(9) < 3);
            step();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if ({tot[i], cnt[i], ovf[i], ir[i], ov[i]} !==
                    {16'(m_total[i]), 8'(m_count[i]), m_ovf[i], !m_hold[i], m_hold[i]}) begin
                    n_fail++;
                    $display("FAIL random cyc%0d dut%0d: got %0d/%0d/%b/%b/%b want %0d/%0d/%b/%b/%b", k, i,
                             tot[i], cnt[i], ovf[i], ir[i], ov[i],
                             m_total[i], m_count[i], m_ovf[i], !m_hold[i], m_hold[i]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_total[i] = 0; m_count[i] = 0; m_ovf[i] = 0; m_hold[i] = 0;
        end
        @(negedge clk);
        test_reset();
        test_frame_hold();
        test_clear();
        test_reset_in_hold();
        test_single();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter: N_SAMPLES, default 4, number of adder results accumulated per output frame; legal range 1..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 clear  input  1  synchronous frame abort; discards partial accumulation.
REQ-005 in_valid  input  1  Sum/C8 carry a valid adder result this cycle.
REQ-006 in_ready  output  1  block can accept an adder result this cycle.
REQ-007 Sum  input  8  sum output of the upstream 8-bit ripple-carry adder.
REQ-008 C8  input  1  carry-out of the upstream adder; bit 8 of the result.
REQ-009 out_valid  output  1  Total/Overflow hold a completed frame.
REQ-010 out_ready  input  1  downstream consumes frame when high with out_valid.
REQ-011 Total  output  16  saturating sum of the N_SAMPLES 9-bit results {C8,Sum}.
REQ-012 Count  output  8  number of results accepted in current frame.
REQ-013 Overflow  output  1  Total saturated during current frame.

Function
REQ-014 Operand value SHALL be the 9-bit unsigned {C8,Sum}, range 0..511, zero-extended to 17 bits before addition.
REQ-015 FSM SHALL have two states: ACCUM and HOLD.
REQ-016 ACCUM: in_ready=1, out_valid=0; HOLD: in_ready=0, out_valid=1.
REQ-017 Accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; values with in_ready=0 are ignored, not queued.
REQ-018 On accept: Total <= min(Total+{C8,Sum}, 65535), Count <= Count+1, visible the following cycle (1-cycle latency).
REQ-019 If the unsaturated sum exceeds 65535, Overflow SHALL set to 1 and stay set until frame end, clear, or reset.
REQ-020 Once saturated, further accepts SHALL leave Total at 65535.
REQ-021 Accept that brings Count to N_SAMPLES SHALL move ACCUM->HOLD; out_valid asserts the next cycle with final Total, Count=N_SAMPLES.
REQ-022 In HOLD, Total, Count, Overflow SHALL be stable while out_ready=0, for any number of cycles.
REQ-023 HOLD with out_ready=1 SHALL move to ACCUM next cycle with Total=0, Count=0, Overflow=0; no result accepted on that edge (in_ready=0 in HOLD).
REQ-024 clear=1 (any state) SHALL on that edge force ACCUM, Total=0, Count=0, Overflow=0; a simultaneous accept or out_ready handshake is discarded.
REQ-025 Priority: reset > clear > handshake/accept.
REQ-026 N_SAMPLES=1: every accept SHALL go directly to HOLD.
REQ-027 Count SHALL never exceed N_SAMPLES; no wrap-around.

Reset
REQ-028 reset=1 on a rising edge SHALL set state=ACCUM, Total=0, Count=0, Overflow=0, out_valid=0, in_ready=1, regardless of state or in-flight handshake.
REQ-029 Reset mid-frame or in HOLD SHALL discard the partial/held frame; no out_valid pulse results.
REQ-030 First accept after reset deassertion is permitted on the first edge where reset=0.

Verification
REQ-031 N_SAMPLES=4, in_valid=1 continuously, results {0,199},{0,55},{0,200},{1,56} (100+99, 22+33, 0+200, 178+134) -> out_valid rises 1 cycle after 4th accept, Total=766, Count=4, Overflow=0.
REQ-032 Same frame with out_ready=0 for 10 cycles, then 1 -> Total=766 held 10+ cycles, in_ready=0 throughout, then next cycle Total=0, Count=0, in_ready=1.
REQ-033 N_SAMPLES=255, 255 results of {1,255}=511 -> Overflow=1 from 129th accept's update, final Total=65535, Count=255.
REQ-034 N_SAMPLES=4, two accepts (199, 55) then clear=1 with in_valid=1 -> Total=0, Count=0, sample on clear edge discarded; next 4 accepts of 10 give Total=40.
REQ-035 reset=1 asserted in HOLD with out_ready=1 -> out_valid=0, Total=0, no frame consumed; in_ready=1 next cycle.
REQ-036 N_SAMPLES=1, result {1,44}=300 -> HOLD after one accept, Total=300, Count=1.
